// File: rtl/conv_pkg.sv
// Shared states and constants for the conv_8_4 controller, its datapath and bench.
package conv_pkg;

   localparam int N_DEF  = 8;
   localparam int M_DEF  = 4;
   localparam int X_AW   = $clog2(N_DEF);
   localparam int F_AW   = $clog2(M_DEF);
   localparam int DIN_W  = 8;
   localparam int DOUT_W = 18;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_COMPUTE,
      ST_WAIT,
      ST_OUTPUT
   } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// j/k counters of the dot-product sweep; produces COMPUTE read addresses and issue flags.
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int M  = M_DEF,
   localparam int XW = $clog2(N),
   localparam int FW = $clog2(M)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clear,
   input  logic          i_step,
   input  logic          i_next_j,
   output logic [XW-1:0] o_addr_x,
   output logic [FW-1:0] o_addr_f,
   output logic          o_first,
   output logic          o_last,
   output logic          o_j_last
);

   localparam logic [FW-1:0] K_LAST = FW'(M - 1);
   localparam logic [XW-1:0] J_LAST = XW'(N - M);

   logic [XW-1:0] r_j;
   logic [FW-1:0] r_k;

   // k wraps to 0 after the last tap, so advancing j alone starts the next dot product
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_j <= '0;
         r_k <= '0;
      end else begin
         if (i_step) begin
            r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
         end
         if (i_next_j) begin
            r_j <= r_j + 1'b1;
         end
      end
   end

   assign o_addr_x = r_j + XW'(r_k);
   assign o_addr_f = r_k;
   assign o_first  = (r_k == '0);
   assign o_last   = (r_k == K_LAST);
   assign o_j_last = (r_j == J_LAST);

endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: load / MAC / output sequencing for the conv_8_4 convolution datapath.
// Define CONV_PERF_EN to add the stall_cnt and iter_done performance outputs.
module conv_ctrl
   import conv_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int M  = M_DEF,
   localparam int XW = $clog2(N),
   localparam int FW = $clog2(M),
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid_x,
   output logic          s_ready_x,
   input  logic          s_valid_f,
   output logic          s_ready_f,
   output logic          m_valid_y,
   input  logic          m_ready_y,
   output logic          wr_en_x,
   output logic          wr_en_f,
   output logic [XW-1:0] addr_x,
   output logic [FW-1:0] addr_f,
   output logic          acc_load,
   output logic          acc_en
`ifdef CONV_PERF_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic          iter_done
`endif
);

   localparam logic [CW-1:0] X_FULL = CW'(N);
   localparam logic [CW-1:0] F_FULL = CW'(M);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_x_cnt, r_f_cnt, w_x_cnt_nxt, w_f_cnt_nxt;
   logic          r_iss_vld, r_iss_first;
   logic          w_ag_clear, w_ag_step, w_ag_next_j;
   logic [XW-1:0] w_ag_addr_x;
   logic [FW-1:0] w_ag_addr_f;
   logic          w_first, w_last, w_j_last;

   conv_addr_gen #(.N(N), .M(M)) u_addr_gen (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_clear  (w_ag_clear),
      .i_step   (w_ag_step),
      .i_next_j (w_ag_next_j),
      .o_addr_x (w_ag_addr_x),
      .o_addr_f (w_ag_addr_f),
      .o_first  (w_first),
      .o_last   (w_last),
      .o_j_last (w_j_last)
   );

   // Issue flags are delayed one cycle so the strobes meet the registered read data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_LOAD;
         r_x_cnt     <= '0;
         r_f_cnt     <= '0;
         r_iss_vld   <= 1'b0;
         r_iss_first <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_x_cnt     <= w_x_cnt_nxt;
         r_f_cnt     <= w_f_cnt_nxt;
         r_iss_vld   <= w_ag_step;
         r_iss_first <= w_ag_step & w_first;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_cnt_nxt = r_x_cnt;
      w_f_cnt_nxt = r_f_cnt;
      w_ag_clear  = 1'b0;
      w_ag_step   = 1'b0;
      w_ag_next_j = 1'b0;
      s_ready_x   = 1'b0;
      s_ready_f   = 1'b0;
      wr_en_x     = 1'b0;
      wr_en_f     = 1'b0;
      m_valid_y   = 1'b0;
      addr_x      = w_ag_addr_x;
      addr_f      = w_ag_addr_f;
      acc_load    = r_iss_vld & r_iss_first;
      acc_en      = r_iss_vld & ~r_iss_first;

      unique case (r_state)
         ST_LOAD: begin
            w_ag_clear = 1'b1;
            s_ready_x  = (r_x_cnt != X_FULL);
            s_ready_f  = (r_f_cnt != F_FULL);
            wr_en_x    = s_valid_x & s_ready_x;
            wr_en_f    = s_valid_f & s_ready_f;
            addr_x     = r_x_cnt[XW-1:0];
            addr_f     = r_f_cnt[FW-1:0];
            if (wr_en_x) w_x_cnt_nxt = r_x_cnt + 1'b1;
            if (wr_en_f) w_f_cnt_nxt = r_f_cnt + 1'b1;
            if ((w_x_cnt_nxt == X_FULL) && (w_f_cnt_nxt == F_FULL)) begin
               w_state_nxt = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            w_ag_step = 1'b1;
            if (w_last) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            w_state_nxt = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            m_valid_y = 1'b1;
            if (m_ready_y) begin
               if (w_j_last) begin
                  w_state_nxt = ST_LOAD;
                  w_x_cnt_nxt = '0;
                  w_f_cnt_nxt = '0;
               end else begin
                  w_state_nxt = ST_COMPUTE;
                  w_ag_next_j = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase

      // Reset is synchronous, so outputs are forced low combinationally in the reset cycle
      if (reset) begin
         s_ready_x   = 1'b0;
         s_ready_f   = 1'b0;
         wr_en_x     = 1'b0;
         wr_en_f     = 1'b0;
         m_valid_y   = 1'b0;
         addr_x      = '0;
         addr_f      = '0;
         acc_load    = 1'b0;
         acc_en      = 1'b0;
         w_ag_step   = 1'b0;
         w_ag_next_j = 1'b0;
      end
   end

`ifdef CONV_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if ((r_state == ST_OUTPUT) && !m_ready_y && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign iter_done = m_valid_y & m_ready_y & w_j_last;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: slot-based behavioural model, behavioural datapath and directed vectors.
`timescale 1ns/1ps
module tb_conv_ctrl;
   import conv_pkg::*;

   localparam int N = N_DEF;
   localparam int M = M_DEF;
   localparam int P = N - M + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              s_valid_x, s_ready_x, s_valid_f, s_ready_f;
   logic              m_valid_y, m_ready_y;
   logic              wr_en_x, wr_en_f, acc_load, acc_en;
   logic [X_AW-1:0]   addr_x;
   logic [F_AW-1:0]   addr_f;
   logic [DIN_W-1:0]  data_x, data_f;
`ifdef CONV_PERF_EN
   logic [31:0]       stall_cnt;
   logic              iter_done;
`endif

   always #5 clk = ~clk;

   conv_ctrl #(.N(N), .M(M)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid_x (s_valid_x),
      .s_ready_x (s_ready_x),
      .s_valid_f (s_valid_f),
      .s_ready_f (s_ready_f),
      .m_valid_y (m_valid_y),
      .m_ready_y (m_ready_y),
      .wr_en_x   (wr_en_x),
      .wr_en_f   (wr_en_f),
      .addr_x    (addr_x),
      .addr_f    (addr_f),
      .acc_load  (acc_load),
      .acc_en    (acc_en)
`ifdef CONV_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .iter_done (iter_done)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural datapath: register files with 1-cycle read, one multiplier, accumulator
   logic [DIN_W-1:0]  xrf [N];
   logic [DIN_W-1:0]  frf [M];
   logic [DIN_W-1:0]  xr, fr;
   logic [15:0]       prod;
   logic [DOUT_W-1:0] acc;

   assign prod = xr * fr;

   always @(posedge clk) begin
      if (wr_en_x === 1'b1) xrf[addr_x] <= data_x;
      if (wr_en_f === 1'b1) frf[addr_f] <= data_f;
      xr <= xrf[addr_x];
      fr <= frf[addr_f];
      if (acc_load === 1'b1)    acc <= {2'b00, prod};
      else if (acc_en === 1'b1) acc <= acc + {2'b00, prod};
   end

   // Model: loading counts, then per output a slot 0..M+1 (M issues, accumulate, present)
   bit model_ok = 1'b0;
   bit mb;
   int mx, mf, mj, ms;
`ifdef CONV_PERF_EN
   logic [31:0] mstall;
`endif

   always @(posedge clk) begin : p_model
      int nx, nf, nj, ns;
      bit nb;
      nx = mx; nf = mf; nj = mj; ns = ms; nb = mb;
      if (reset === 1'b1) begin
         nb = 1'b0; nx = 0; nf = 0; nj = 0; ns = 0;
         model_ok <= 1'b1;
`ifdef CONV_PERF_EN
         mstall <= '0;
`endif
      end else if (model_ok) begin
`ifdef CONV_PERF_EN
         if (mb && ms == M + 1 && !m_ready_y && mstall != 32'hFFFF_FFFF) mstall <= mstall + 1;
`endif
         if (!mb) begin
            if (s_valid_x && mx < N) nx = mx + 1;
            if (s_valid_f && mf < M) nf = mf + 1;
            if (nx == N && nf == M) begin nb = 1'b1; ns = 0; nj = 0; end
         end else if (ms < M + 1) begin
            ns = ms + 1;
         end else if (m_ready_y) begin
            if (mj < P - 1) begin nj = mj + 1; ns = 0; end
            else begin nb = 1'b0; nx = 0; nf = 0; end
         end
      end
      mx <= nx; mf <= nf; mj <= nj; ms <= ns; mb <= nb;
   end

   int  exp_y[$];
   int  cnt_wrx, cnt_wrf;
   bit  trace_en = 1'b0;
   int  tr_x[$];
   int  tr_f[$];

   always @(negedge clk) begin : p_cmp
      logic e_rx, e_rf, e_wx, e_wf, e_ld, e_en, e_vy;
      int   e_ax, e_af;
      bit   c_ax, c_af;
      if (model_ok) begin
         e_rx = 0; e_rf = 0; e_wx = 0; e_wf = 0; e_ld = 0; e_en = 0; e_vy = 0;
         e_ax = 0; e_af = 0; c_ax = 0; c_af = 0;
         if (reset) begin
            c_ax = 1; c_af = 1;
         end else if (!mb) begin
            e_rx = (mx < N);
            e_rf = (mf < M);
            e_wx = s_valid_x & e_rx;
            e_wf = s_valid_f & e_rf;
            c_ax = e_rx; e_ax = mx;
            c_af = e_rf; e_af = mf;
         end else begin
            e_ld = (ms == 1);
            e_en = (ms >= 2 && ms <= M);
            e_vy = (ms == M + 1);
            c_ax = (ms < M); e_ax = mj + ms;
            c_af = (ms < M); e_af = ms;
         end
         chk("s_ready_x", s_ready_x, e_rx);
         chk("s_ready_f", s_ready_f, e_rf);
         chk("wr_en_x", wr_en_x, e_wx);
         chk("wr_en_f", wr_en_f, e_wf);
         chk("acc_load", acc_load, e_ld);
         chk("acc_en", acc_en, e_en);
         chk("m_valid_y", m_valid_y, e_vy);
         if (c_ax) chk("addr_x", addr_x, e_ax);
         if (c_af) chk("addr_f", addr_f, e_af);
         if (wr_en_x === 1'b1) cnt_wrx++;
         if (wr_en_f === 1'b1) cnt_wrf++;
         if (!reset && m_valid_y === 1'b1) begin
            if (exp_y.size() == 0) chk("y_expected_avail", exp_y.size(), 1);
            else begin
               chk("y_data", acc, exp_y[0]);
               if (m_ready_y) void'(exp_y.pop_front());
            end
         end
         if (trace_en && !reset && mb && mj == 4 && ms < M) begin
            tr_x.push_back(int'(addr_x));
            tr_f.push_back(int'(addr_f));
         end
`ifdef CONV_PERF_EN
         chk("stall_cnt", stall_cnt, mstall);
         chk("iter_done", iter_done, !reset && mb && ms == M + 1 && m_ready_y && mj == P - 1);
`endif
      end
   end

   logic [DIN_W-1:0] gx [N];
   logic [DIN_W-1:0] gf [M];
   int load_done;
   int y_cyc[$];
   int y_got[$];

   task automatic do_reset();
      reset = 1'b1;
      s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
      data_x = 'x; data_f = 'x;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Called at posedge+1; percent probabilities for valids/ready, optional stall or abort at output j
   task automatic run_iter(input int pvx, input int pvf, input int prd, input int xdelay,
                           input int stall_j, input int stall_len, input int abort_j);
      int xi = 0, fi = 0, outs = 0, cyc = 0, stall_left = stall_len, abort_cnt = 0, s;
      bit hsx, hsf, hy;
      for (int j = 0; j < P; j++) begin
         s = 0;
         for (int k = 0; k < M; k++) s += int'(gx[j + k]) * int'(gf[k]);
         exp_y.push_back(s);
      end
      y_cyc.delete(); y_got.delete(); load_done = -1; cnt_wrx = 0; cnt_wrf = 0;
      while (outs < P) begin
         if (cyc >= 3000) begin
            chk("iter_timeout_outputs", outs, P);
            break;
         end
         if (abort_j >= 0 && outs == abort_j) begin
            if (abort_cnt == 2) begin
               reset = 1'b1;
               s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
               data_x = 'x; data_f = 'x;
               @(negedge clk);
               chk("abort_m_valid_y", m_valid_y, 0);
               chk("abort_acc_en", acc_en, 0);
               @(posedge clk);
               #1 reset = 1'b0;
               exp_y.delete();
               return;
            end
            abort_cnt++;
         end
         s_valid_x = (xi < N) && (cyc >= xdelay) && ($urandom_range(0, 99) < pvx);
         s_valid_f = (fi < M) && ($urandom_range(0, 99) < pvf);
         data_x = s_valid_x ? gx[xi] : 'x;
         data_f = s_valid_f ? gf[fi] : 'x;
         m_ready_y = !(outs == stall_j && stall_left > 0) && ($urandom_range(0, 99) < prd);
         @(negedge clk);
         hsx = s_valid_x && s_ready_x;
         hsf = s_valid_f && s_ready_f;
         hy  = m_valid_y && m_ready_y;
         if (m_valid_y && outs == stall_j && stall_left > 0) stall_left--;
         if (hy) begin y_cyc.push_back(cyc); y_got.push_back(int'(acc)); end
         @(posedge clk);
         #1;
         if (hsx) xi++;
         if (hsf) fi++;
         if (hy) outs++;
         if ((hsx || hsf) && xi == N && fi == M) load_done = cyc;
         cyc++;
      end
      s_valid_x = 1'b0; s_valid_f = 1'b0; data_x = 'x; data_f = 'x;
   endtask

   int y_total;

   initial begin
      reset = 1'b1;
      s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
      data_x = 'x; data_f = 'x;
      do_reset();
      @(negedge clk);
      chk("reset_ready_x", s_ready_x, 1);
      chk("reset_m_valid_y", m_valid_y, 0);
      @(posedge clk); #1;

      // Test 1: everything streaming, x=1..8, f=1 -> y = 10,14,18,22,26; j=4 address trace
      for (int i = 0; i < N; i++) gx[i] = DIN_W'(i + 1);
      for (int k = 0; k < M; k++) gf[k] = 8'd1;
      trace_en = 1'b1; tr_x.delete(); tr_f.delete();
      run_iter(100, 100, 100, 0, -1, 0, -1);
      trace_en = 1'b0;
      chk("t1_load_done_cycle", load_done, 7);
      chk("t1_first_latency", y_cyc[0] - load_done, 6);
      for (int i = 1; i < P; i++) chk("t1_spacing", y_cyc[i] - y_cyc[i - 1], 6);
      chk("t1_y0", y_got[0], 10);
      chk("t1_y4", y_got[4], 26);
      chk("t1_wr_x_count", cnt_wrx, 8);
      chk("t1_wr_f_count", cnt_wrf, 4);
      chk("t1_trace_len", tr_x.size(), 4);
      for (int k = 0; k < M && k < tr_x.size(); k++) begin
         chk("t1_trace_addr_x", tr_x[k], 4 + k);
         chk("t1_trace_addr_f", tr_f[k], k);
      end
      @(negedge clk);
      chk("t1_back_in_load", s_ready_x, 1);
      @(posedge clk); #1;

      // Test 2: filter loaded first, x held off for 10 cycles
      for (int i = 0; i < N; i++) gx[i] = DIN_W'(3 * i + 2);
      for (int k = 0; k < M; k++) gf[k] = DIN_W'(k + 5);
      run_iter(100, 100, 100, 10, -1, 0, -1);
      chk("t2_load_done_cycle", load_done, 17);
      chk("t2_first_latency", y_cyc[0] - load_done, 6);
      chk("t2_wr_f_count", cnt_wrf, 4);
      chk("t2_wr_x_count", cnt_wrx, 8);

      // Test 3: 20-cycle output stall at j=2, full-scale data
      do_reset();
      for (int i = 0; i < N; i++) gx[i] = 8'hFF;
      for (int k = 0; k < M; k++) gf[k] = 8'hFF;
      run_iter(100, 100, 100, 0, 2, 20, -1);
      chk("t3_y_max", y_got[2], 260100);
      chk("t3_stall_spacing", y_cyc[2] - y_cyc[1], 26);
`ifdef CONV_PERF_EN
      @(negedge clk);
      chk("t3_stall_cnt", stall_cnt, 20);
      @(posedge clk); #1;
`endif

      // Test 5: reset mid-compute at j=1, then a fresh load
      for (int i = 0; i < N; i++) gx[i] = DIN_W'(i * 7 + 1);
      for (int k = 0; k < M; k++) gf[k] = DIN_W'(9 - k);
      run_iter(100, 100, 100, 0, -1, 0, 1);
      @(negedge clk);
      chk("t5_after_reset_ready_x", s_ready_x, 1);
      chk("t5_after_reset_ready_f", s_ready_f, 1);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) gx[i] = DIN_W'(i + 10);
      for (int k = 0; k < M; k++) gf[k] = DIN_W'(2 * k + 1);
      run_iter(100, 100, 100, 0, -1, 0, -1);
      chk("t5_y0", y_got[0], 10 * 1 + 11 * 3 + 12 * 5 + 13 * 7);

      // Test 6: 10 back-to-back iterations with 50% valid/ready
      y_total = 0;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < N; i++) gx[i] = DIN_W'($urandom_range(0, 255));
         for (int k = 0; k < M; k++) gf[k] = DIN_W'($urandom_range(0, 255));
         run_iter(50, 50, 50, 0, -1, 0, -1);
         y_total += y_cyc.size();
      end
      chk("t6_total_outputs", y_total, 50);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
